// File: rtl/lsu_ad_arb.sv
// rtl/lsu_ad_arb.sv - LSU address generation, issue buffer and dcache-stage arbiter
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_flush                  drops buffered ops and the output register
//   i_lq_full, i_sq_full     queue back-pressure folded into o_ready
//   i_valid/i_insn/i_src_a/i_src_b/i_tag, o_ready
//                            issued load/store; accepted on i_valid & o_ready
//   i_req_*                  packed replay/retire requesters, ch0 highest priority
//   o_req_ack                one-hot combinational grant to requesters
//   i_stall                  downstream stall; holds the output register
//   o_valid/o_src/o_lsu_func/o_tag/o_addr/o_data/o_sel/o_misaligned
//                            registered winner feeding the dcache stage
//   o_alloc_lq_en, o_alloc_sq_en
//                            one-cycle LQ/SQ allocate for issue-sourced ops
//   lsu_func encoding: {is_store, size/sign funct3}
module lsu_ad_arb #(
  parameter int OPTN_DATA_WIDTH     = 32,
  parameter int OPTN_ADDR_WIDTH     = 32,
  parameter int OPTN_ROB_IDX_WIDTH  = 5,
  parameter int OPTN_NUM_REQ        = 2,
  parameter int OPTN_SEL_WIDTH      = 8,
  parameter int OPTN_STARVE_LIMIT   = 4,
  parameter int PCYN_LSU_FUNC_WIDTH = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_flush,
  input  logic                                        i_lq_full,
  input  logic                                        i_sq_full,
  input  logic                                        i_valid,
  input  logic [OPTN_DATA_WIDTH-1:0]                  i_insn,
  input  logic [OPTN_DATA_WIDTH-1:0]                  i_src_a,
  input  logic [OPTN_DATA_WIDTH-1:0]                  i_src_b,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]               i_tag,
  output logic                                        o_ready,
  input  logic [OPTN_NUM_REQ-1:0]                     i_req_valid,
  input  logic [OPTN_NUM_REQ*OPTN_ROB_IDX_WIDTH-1:0]  i_req_tag,
  input  logic [OPTN_NUM_REQ*OPTN_ADDR_WIDTH-1:0]     i_req_addr,
  input  logic [OPTN_NUM_REQ*OPTN_DATA_WIDTH-1:0]     i_req_data,
  input  logic [OPTN_NUM_REQ*PCYN_LSU_FUNC_WIDTH-1:0] i_req_lsu_func,
  input  logic [OPTN_NUM_REQ*OPTN_SEL_WIDTH-1:0]      i_req_sel,
  output logic [OPTN_NUM_REQ-1:0]                     o_req_ack,
  input  logic                                        i_stall,
  output logic                                        o_valid,
  output logic [OPTN_NUM_REQ:0]                       o_src,
  output logic [PCYN_LSU_FUNC_WIDTH-1:0]              o_lsu_func,
  output logic [OPTN_ROB_IDX_WIDTH-1:0]               o_tag,
  output logic [OPTN_ADDR_WIDTH-1:0]                  o_addr,
  output logic [OPTN_DATA_WIDTH-1:0]                  o_data,
  output logic [OPTN_SEL_WIDTH-1:0]                   o_sel,
  output logic                                        o_misaligned,
  output logic                                        o_alloc_lq_en,
  output logic                                        o_alloc_sq_en
);

  localparam int D     = OPTN_DATA_WIDTH;
  localparam int A     = OPTN_ADDR_WIDTH;
  localparam int T     = OPTN_ROB_IDX_WIDTH;
  localparam int R     = OPTN_NUM_REQ;
  localparam int S     = OPTN_SEL_WIDTH;
  localparam int F     = PCYN_LSU_FUNC_WIDTH;
  localparam int AGE_W = $clog2(OPTN_STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(OPTN_STARVE_LIMIT);

  typedef struct packed {
    logic [F-1:0] func;
    logic [T-1:0] tag;
    logic [A-1:0] addr;
    logic [D-1:0] data;
    logic         mis;
    logic         store;
  } entry_t;

  // ---------------- decode / address generation ----------------
  logic [2:0]   funct3;
  logic [2:0]   f3_eff;
  logic         is_store;
  logic [11:0]  imm12;
  logic [A-1:0] imm_ext;
  logic [A-1:0] dec_addr;
  logic [F-1:0] dec_func;
  logic         dec_mis;
  entry_t       new_entry;
  logic         unused;

  assign funct3   = i_insn[14:12];
  assign is_store = (i_insn[6:0] == 7'b0100011);
  assign imm12    = is_store ? {i_insn[31:25], i_insn[11:7]} : i_insn[31:20];
  assign imm_ext  = {{(A-12){imm12[11]}}, imm12};
  assign dec_addr = i_src_a[A-1:0] + imm_ext;
  assign unused   = ^i_insn[19:15];

  // Stores have no unsigned forms; anything outside the legal set is word.
  always_comb begin
    f3_eff = 3'b010;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_eff = funct3;
      3'b100, 3'b101:         f3_eff = is_store ? 3'b010 : funct3;
      default:                f3_eff = 3'b010;
    endcase
  end

  always_comb begin
    dec_func      = '0;
    dec_func[3:0] = {is_store, f3_eff};
  end

  assign dec_mis = ((f3_eff[1:0] == 2'b01) & dec_addr[0]) |
                   ((f3_eff[1:0] == 2'b10) & (dec_addr[1:0] != 2'b00));

  assign new_entry = '{func: dec_func, tag: i_tag, addr: dec_addr,
                       data: i_src_b, mis: dec_mis, store: is_store};

  // ---------------- issue buffer ----------------
  entry_t           buf_q [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count, count_next;
  logic [AGE_W-1:0] age;
  entry_t           head;
  logic             head_valid;
  logic             accept;

  assign head       = buf_q[rd_ptr];
  assign head_valid = (count != 2'd0);
  assign accept     = i_valid & o_ready & ~i_flush;

  // ---------------- arbitration ----------------
  logic         arb_en;
  logic         iss_gnt;
  logic [R-1:0] req_gnt;
  logic         found;
  logic         grant_any;

  assign arb_en = ~i_stall & ~i_flush;

  always_comb begin
    iss_gnt = 1'b0;
    req_gnt = '0;
    found   = 1'b0;
    if (arb_en) begin
      if (head_valid && age == AGE_MAX) begin
        iss_gnt = 1'b1;
      end else begin
        for (int i = 0; i < R; i++) begin
          if (i_req_valid[i] && !found) begin
            req_gnt[i] = 1'b1;
            found      = 1'b1;
          end
        end
        if (!found && head_valid) iss_gnt = 1'b1;
      end
    end
  end

  assign o_req_ack = req_gnt;
  assign grant_any = iss_gnt | (|req_gnt);

  always_comb begin
    count_next = count + {1'b0, accept} - {1'b0, iss_gnt};
    if (i_flush) count_next = 2'd0;
  end

  // Winner datapath: issue head by default, overridden by the granted requester.
  logic [F-1:0] m_func;
  logic [T-1:0] m_tag;
  logic [A-1:0] m_addr;
  logic [D-1:0] m_data;
  logic [S-1:0] m_sel;
  logic         m_mis;

  always_comb begin
    m_func = head.func;
    m_tag  = head.tag;
    m_addr = head.addr;
    m_data = head.data;
    m_sel  = '0;
    m_mis  = head.mis;
    for (int i = 0; i < R; i++) begin
      if (req_gnt[i]) begin
        m_func = i_req_lsu_func[i*F +: F];
        m_tag  = i_req_tag[i*T +: T];
        m_addr = i_req_addr[i*A +: A];
        m_data = i_req_data[i*D +: D];
        m_sel  = i_req_sel[i*S +: S];
        m_mis  = 1'b0;
      end
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= 2'd0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      age           <= '0;
      o_ready       <= 1'b0;
      o_valid       <= 1'b0;
      o_src         <= '0;
      o_lsu_func    <= '0;
      o_tag         <= '0;
      o_addr        <= '0;
      o_data        <= '0;
      o_sel         <= '0;
      o_misaligned  <= 1'b0;
      o_alloc_lq_en <= 1'b0;
      o_alloc_sq_en <= 1'b0;
    end else begin
      count   <= count_next;
      // Ready is a cycle late, so only advertise it while a further
      // accept could not overflow the two entries.
      o_ready <= ~i_flush & ~i_lq_full & ~i_sq_full & (count_next <= 2'd1);

      if (i_flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (accept) begin
          buf_q[wr_ptr] <= new_entry;
          wr_ptr        <= ~wr_ptr;
        end
        if (iss_gnt) rd_ptr <= ~rd_ptr;
      end

      if (i_flush || !head_valid || iss_gnt) age <= '0;
      else if (age != AGE_MAX)               age <= age + 1'b1;

      if (i_flush) begin
        o_valid       <= 1'b0;
        o_alloc_lq_en <= 1'b0;
        o_alloc_sq_en <= 1'b0;
      end else if (i_stall) begin
        o_alloc_lq_en <= 1'b0;
        o_alloc_sq_en <= 1'b0;
      end else begin
        o_valid       <= grant_any;
        o_alloc_lq_en <= iss_gnt & ~head.store;
        o_alloc_sq_en <= iss_gnt & head.store;
        if (grant_any) begin
          o_src        <= {iss_gnt, req_gnt};
          o_lsu_func   <= m_func;
          o_tag        <= m_tag;
          o_addr       <= m_addr;
          o_data       <= m_data;
          o_sel        <= m_sel;
          o_misaligned <= m_mis;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_ad_arb.sv
// tb/tb_lsu_ad_arb.sv - directed self-checking bench for lsu_ad_arb
module tb_lsu_ad_arb;

  logic        clk;
  logic        rst;
  logic        i_flush, i_lq_full, i_sq_full, i_valid;
  logic [31:0] i_insn, i_src_a, i_src_b;
  logic [4:0]  i_tag;
  logic        o_ready;
  logic [1:0]  i_req_valid;
  logic [9:0]  i_req_tag;
  logic [63:0] i_req_addr, i_req_data;
  logic [7:0]  i_req_lsu_func;
  logic [15:0] i_req_sel;
  logic [1:0]  o_req_ack;
  logic        i_stall;
  logic        o_valid;
  logic [2:0]  o_src;
  logic [3:0]  o_lsu_func;
  logic [4:0]  o_tag;
  logic [31:0] o_addr, o_data;
  logic [7:0]  o_sel;
  logic        o_misaligned, o_alloc_lq_en, o_alloc_sq_en;

  int total;
  int bad;

  lsu_ad_arb dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_lq_full(i_lq_full), .i_sq_full(i_sq_full),
    .i_valid(i_valid), .i_insn(i_insn), .i_src_a(i_src_a), .i_src_b(i_src_b), .i_tag(i_tag),
    .o_ready(o_ready), .i_req_valid(i_req_valid), .i_req_tag(i_req_tag), .i_req_addr(i_req_addr),
    .i_req_data(i_req_data), .i_req_lsu_func(i_req_lsu_func), .i_req_sel(i_req_sel),
    .o_req_ack(o_req_ack), .i_stall(i_stall), .o_valid(o_valid), .o_src(o_src),
    .o_lsu_func(o_lsu_func), .o_tag(o_tag), .o_addr(o_addr), .o_data(o_data), .o_sel(o_sel),
    .o_misaligned(o_misaligned), .o_alloc_lq_en(o_alloc_lq_en), .o_alloc_sq_en(o_alloc_sq_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_ld(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd1, f3, 5'd2, 7'b0000011};
  endfunction

  function automatic logic [31:0] mk_st(input logic [11:0] imm, input logic [2:0] f3);
    return {imm[11:5], 5'd3, 5'd1, f3, imm[4:0], 7'b0100011};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", o_valid); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0h exp=0", o_ready); end
    total++; if (o_src !== 3'b000) begin bad++; $display("FAIL rst_src got=%0h exp=0", o_src); end
    total++; if ({o_alloc_lq_en, o_alloc_sq_en, o_misaligned} !== 3'b000) begin
      bad++; $display("FAIL rst_flags got=%0h exp=0", {o_alloc_lq_en, o_alloc_sq_en, o_misaligned}); end
    total++; if (o_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", o_addr); end
    rst = 1'b0;
    step;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%0h exp=1", o_ready); end
  endtask

  task automatic test_lw;
    i_valid = 1'b1; i_insn = mk_ld(12'd8, 3'b010); i_src_a = 32'h100; i_src_b = 32'h0; i_tag = 5'd3;
    step;
    i_valid = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL lw_early got=%0h exp=0", o_valid); end
    step;
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL lw_valid got=%0h exp=1", o_valid); end
    total++; if (o_addr !== 32'h108) begin bad++; $display("FAIL lw_addr got=%0h exp=108", o_addr); end
    total++; if (o_src !== 3'b100) begin bad++; $display("FAIL lw_src got=%0h exp=4", o_src); end
    total++; if (o_lsu_func !== 4'b0010) begin bad++; $display("FAIL lw_func got=%0h exp=2", o_lsu_func); end
    total++; if (o_tag !== 5'd3) begin bad++; $display("FAIL lw_tag got=%0h exp=3", o_tag); end
    total++; if ({o_alloc_lq_en, o_alloc_sq_en} !== 2'b10) begin
      bad++; $display("FAIL lw_alloc got=%0h exp=2", {o_alloc_lq_en, o_alloc_sq_en}); end
    step;
    total++; if ({o_valid, o_alloc_lq_en} !== 2'b00) begin
      bad++; $display("FAIL lw_pulse_once got=%0h exp=0", {o_valid, o_alloc_lq_en}); end
  endtask

  task automatic test_two_req;
    i_req_tag = {5'd2, 5'd1};
    i_req_addr = {32'hB000_0010, 32'hA000_0020};
    i_req_data = {32'h2222_2222, 32'h1111_1111};
    i_req_lsu_func = {4'b0000, 4'b1010};
    i_req_sel = {8'd7, 8'd5};
    i_req_valid = 2'b11;
    #1;
    total++; if (o_req_ack !== 2'b01) begin bad++; $display("FAIL req_ack0 got=%0h exp=1", o_req_ack); end
    step;
    i_req_valid = 2'b10;
    total++; if (o_src !== 3'b001 || o_valid !== 1'b1) begin
      bad++; $display("FAIL req_out0 got=%0h exp=9", {o_valid, o_src}); end
    total++; if (o_addr !== 32'hA000_0020 || o_sel !== 8'd5 || o_tag !== 5'd1) begin
      bad++; $display("FAIL req_data0 got=%0h exp=a0000020", o_addr); end
    #1;
    total++; if (o_req_ack !== 2'b10) begin bad++; $display("FAIL req_ack1 got=%0h exp=2", o_req_ack); end
    step;
    i_req_valid = 2'b00;
    total++; if (o_src !== 3'b010 || o_addr !== 32'hB000_0010 || o_data !== 32'h2222_2222) begin
      bad++; $display("FAIL req_out1 got=%0h exp=2", o_src); end
    step;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL req_idle got=%0h exp=0", o_valid); end
  endtask

  task automatic test_starve;
    i_req_valid = 2'b01;
    i_valid = 1'b1; i_insn = mk_st(12'h010, 3'b010); i_src_a = 32'h200; i_src_b = 32'hDEAD_BEEF; i_tag = 5'd9;
    step;
    i_insn = mk_st(12'h014, 3'b010); i_tag = 5'd10;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL starve_ready got=%0h exp=1", o_ready); end
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (o_req_ack !== 2'b01) begin bad++; $display("FAIL starve_lose%0d got=%0h exp=1", k, o_req_ack); end
      step;
      i_valid = 1'b0;
    end
    #1;
    total++; if (o_req_ack !== 2'b00) begin bad++; $display("FAIL starve_win got=%0h exp=0", o_req_ack); end
    step;
    total++; if (o_src !== 3'b100 || o_addr !== 32'h210 || o_alloc_sq_en !== 1'b1) begin
      bad++; $display("FAIL starve_out got=%0h exp=210", o_addr); end
    total++; if (o_data !== 32'hDEAD_BEEF || o_lsu_func !== 4'b1010) begin
      bad++; $display("FAIL starve_data got=%0h exp=deadbeef", o_data); end
    // second op must lose a full four cycles again once the age clears
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (o_req_ack !== 2'b01) begin bad++; $display("FAIL starve2_lose%0d got=%0h exp=1", k, o_req_ack); end
      step;
    end
    #1;
    total++; if (o_req_ack !== 2'b00) begin bad++; $display("FAIL starve2_win got=%0h exp=0", o_req_ack); end
    step;
    i_req_valid = 2'b00;
    total++; if (o_src !== 3'b100 || o_addr !== 32'h214 || o_tag !== 5'd10) begin
      bad++; $display("FAIL starve2_out got=%0h exp=214", o_addr); end
    step;
  endtask

  task automatic test_misaligned;
    i_valid = 1'b1; i_insn = mk_st(12'd3, 3'b001); i_src_a = 32'h100; i_src_b = 32'h1234_5678; i_tag = 5'd4;
    step;
    i_valid = 1'b0;
    step;
    total++; if (o_misaligned !== 1'b1 || o_addr !== 32'h103) begin
      bad++; $display("FAIL sh_mis got=%0h exp=1", o_misaligned); end
    total++; if ({o_alloc_lq_en, o_alloc_sq_en} !== 2'b01 || o_lsu_func !== 4'b1001) begin
      bad++; $display("FAIL sh_alloc got=%0h exp=1", {o_alloc_lq_en, o_alloc_sq_en}); end
    total++; if (o_data !== 32'h1234_5678) begin bad++; $display("FAIL sh_data got=%0h exp=12345678", o_data); end
    // negative immediate, halfword-aligned unsigned load
    i_valid = 1'b1; i_insn = mk_ld(12'hFFE, 3'b101); i_src_a = 32'h100; i_tag = 5'd6;
    step;
    i_valid = 1'b0;
    step;
    total++; if (o_addr !== 32'hFE || o_misaligned !== 1'b0 || o_lsu_func !== 4'b0101) begin
      bad++; $display("FAIL lhu_neg got=%0h exp=fe", o_addr); end
    total++; if ({o_alloc_lq_en, o_alloc_sq_en} !== 2'b10) begin
      bad++; $display("FAIL lhu_alloc got=%0h exp=2", {o_alloc_lq_en, o_alloc_sq_en}); end
    step;
  endtask

  task automatic test_stall;
    int pulses;
    pulses = 0;
    i_valid = 1'b1; i_insn = mk_ld(12'd0, 3'b010); i_src_a = 32'h300; i_tag = 5'd12;
    step;
    i_valid = 1'b0;
    step;
    pulses += int'(o_alloc_lq_en);
    total++; if (o_valid !== 1'b1 || o_addr !== 32'h300) begin
      bad++; $display("FAIL stall_first got=%0h exp=300", o_addr); end
    i_stall = 1'b1; i_req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (o_req_ack !== 2'b00) begin bad++; $display("FAIL stall_ack%0d got=%0h exp=0", k, o_req_ack); end
      step;
      pulses += int'(o_alloc_lq_en);
      total++; if (o_valid !== 1'b1 || o_addr !== 32'h300 || o_src !== 3'b100) begin
        bad++; $display("FAIL stall_hold%0d got=%0h exp=300", k, o_addr); end
    end
    i_stall = 1'b0;
    #1;
    total++; if (o_req_ack !== 2'b01) begin bad++; $display("FAIL stall_release got=%0h exp=1", o_req_ack); end
    step;
    pulses += int'(o_alloc_lq_en);
    i_req_valid = 2'b00;
    total++; if (o_src !== 3'b001) begin bad++; $display("FAIL stall_next got=%0h exp=1", o_src); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL stall_pulses got=%0d exp=1", pulses); end
    step;
  endtask

  task automatic test_flush;
    i_req_valid = 2'b01;
    i_valid = 1'b1; i_insn = mk_ld(12'd4, 3'b010); i_src_a = 32'h400; i_tag = 5'd1;
    step;
    i_tag = 5'd2;
    step;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0h exp=0", o_ready); end
    total++; if (o_valid !== 1'b1 || o_src !== 3'b001) begin
      bad++; $display("FAIL full_out got=%0h exp=9", {o_valid, o_src}); end
    i_flush = 1'b1; i_stall = 1'b1;
    #1;
    total++; if (o_req_ack !== 2'b00) begin bad++; $display("FAIL flush_ack got=%0h exp=0", o_req_ack); end
    step;
    i_flush = 1'b0; i_stall = 1'b0; i_valid = 1'b0; i_req_valid = 2'b00;
    total++; if ({o_valid, o_ready, o_alloc_lq_en, o_alloc_sq_en} !== 4'b0000) begin
      bad++; $display("FAIL flush_state got=%0h exp=0", {o_valid, o_ready, o_alloc_lq_en, o_alloc_sq_en}); end
    step;
    total++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      bad++; $display("FAIL flush_after got=%0h exp=2", {o_ready, o_valid}); end
    step;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%0h exp=0", o_valid); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; i_flush = 1'b0; i_lq_full = 1'b0; i_sq_full = 1'b0; i_valid = 1'b0;
    i_insn = '0; i_src_a = '0; i_src_b = '0; i_tag = '0; i_req_valid = '0; i_req_tag = '0;
    i_req_addr = '0; i_req_data = '0; i_req_lsu_func = '0; i_req_sel = '0; i_stall = 1'b0;
    test_reset;
    test_lw;
    test_two_req;
    test_starve;
    test_misaligned;
    test_stall;
    test_flush;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
